// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding a single FIFO write port
module fifo_wr_arbiter #(
  parameter int WIDTH   = 512,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wrreq,
  output logic [WIDTH-1:0]           fifo_data,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic [31:0]                pkt_count
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    nxt_ptr;
  logic [NUM_REQ-1:0] gmask;
  logic               found;
  logic               xfer;
  logic               last;
  // first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    sel = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && |(req_valid & (NUM_REQ'(1) << j))) begin
        found = 1'b1;
        sel = ID_W'(j);
      end
    end
  end
  // zero-latency datapath from the granted requester to the FIFO
  always_comb begin
    gmask      = NUM_REQ'(1) << grant_id;
    busy       = state == BURST;
    xfer       = busy && |(req_valid & gmask) && !fifo_full;
    last       = |(req_last & gmask);
    req_ready  = (busy && !fifo_full) ? gmask : '0;
    fifo_wrreq = xfer;
    fifo_data  = WIDTH'(req_data >> (int'(grant_id) * WIDTH));
    nxt_ptr    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  end
  // grant on arbitration, release and advance the pointer on the last beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      pkt_count <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state    <= BURST;
        grant_id <= sel;
      end
    end else if (xfer && last) begin
      state     <= IDLE;
      rr_ptr    <= nxt_ptr;
      pkt_count <= pkt_count + 32'd1;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001: Parameter WIDTH, default 512, SHALL set the data width of every requester and of the FIFO write port.
REQ-002: Parameter NUM_REQ, default 4, SHALL set the number of requesters; legal range 1..16.
REQ-003: Parameter ID_W, default 2, SHALL set the grant_id width; ID_W >= max(1, ceil(log2(NUM_REQ))).
REQ-004: clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005: reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006: req_valid  input  NUM_REQ  SHALL carry the per-requester beat-valid flags.
REQ-007: req_last  input  NUM_REQ  SHALL mark the final beat of a requester's burst; sampled only with req_valid.
REQ-008: req_data  input  NUM_REQ*WIDTH  SHALL carry requester i's beat in bits [i*WIDTH +: WIDTH].
REQ-009: req_ready  output  NUM_REQ  SHALL indicate that requester i's beat is accepted this cycle when req_valid[i] is also high.
REQ-010: fifo_full  input  1  SHALL be the full flag of the downstream FIFO.
REQ-011: fifo_wrreq  output  1  SHALL be the downstream FIFO write enable.
REQ-012: fifo_data  output  WIDTH  SHALL be the downstream FIFO write data.
REQ-013: grant_id  output  ID_W  SHALL be the index of the currently granted requester.
REQ-014: busy  output  1  SHALL be high while a burst is granted.
REQ-015: pkt_count  output  32  SHALL count completed bursts; wraps at 2^32.

Function
REQ-016: The block SHALL have two states, IDLE and BURST; busy = (state == BURST).
REQ-017: In IDLE, if any req_valid is high, the block SHALL select the first requester with req_valid high, searching from rr_ptr upward modulo NUM_REQ, register it into grant_id and enter BURST on the next edge.
REQ-018: In IDLE with no req_valid high, the block SHALL remain in IDLE with grant_id unchanged.
REQ-019: In IDLE, req_ready SHALL be all zeros and fifo_wrreq SHALL be 0.
REQ-020: In BURST, req_ready[grant_id] SHALL equal !fifo_full (combinational); all other req_ready bits SHALL be 0.
REQ-021: A transfer SHALL occur when in BURST, req_valid[grant_id] = 1 and fifo_full = 0; then fifo_wrreq = 1 and fifo_data = req_data slice grant_id, same cycle (zero latency).
REQ-022: With no transfer, fifo_wrreq SHALL be 0; fifo_data is don't-care.
REQ-023: A transfer with req_last[grant_id] = 1 SHALL move the state to IDLE, set rr_ptr to (grant_id + 1) mod NUM_REQ and increment pkt_count, all on the same edge.
REQ-024: The grant SHALL be held across cycles where the granted requester drops req_valid or fifo_full is high; no other requester is served until the last beat.
REQ-025: Minimum spacing: last beat at cycle t, arbitration in IDLE at t+1, next first beat no earlier than t+2.
REQ-026: A single-beat burst (req_valid and req_last high together) SHALL be legal and SHALL complete in one BURST cycle.
REQ-027: Changes to other requesters' req_valid during a BURST SHALL have no effect until return to IDLE.
REQ-028: With NUM_REQ = 1, rr_ptr and grant_id SHALL stay 0.

Reset
REQ-029: While reset_n is low, state SHALL be IDLE, rr_ptr = 0, grant_id = 0 and pkt_count = 0, taking effect immediately without a clock edge.
REQ-030: During reset, req_ready, fifo_wrreq and busy SHALL be 0 combinationally; a burst in progress is abandoned and no partial-burst completion is counted.
REQ-031: After reset_n deasserts, the first arbitration SHALL occur on the first rising edge at which reset_n is high.

Verification
REQ-032: Reset, then req_valid=4'b0100 with a 3-beat burst, fifo_full=0 -> grant_id=2 after 1 cycle; 3 consecutive fifo_wrreq pulses with data in order; pkt_count=1; rr_ptr=3.
REQ-033: All four requesters continuously valid with 2-beat bursts from reset -> grant order 0,1,2,3,0; each burst separated by exactly one idle cycle; pkt_count=5 after five bursts.
REQ-034: fifo_full held high for 5 cycles mid-burst -> req_ready and fifo_wrreq low for those 5 cycles, grant_id unchanged, no beat lost or duplicated after release.
REQ-035: Granted requester deasserts req_valid for 3 cycles while requester 3 is valid -> no grant change and no fifo_wrreq until the granted burst's last beat.
REQ-036: Assert reset_n low asynchronously mid-burst (between edges) -> busy, req_ready, fifo_wrreq drop immediately; pkt_count=0; after release, arbitration restarts from requester 0.
REQ-037: Single-beat bursts from requesters 1 and 3 simultaneously valid, rr_ptr=2 -> requester 3 served first, then requester 1; pkt_count increments by 2.
